// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the execute-stage load/store interface. Accepts
//   one request at a time, performs it on an internal word-addressed RAM and
//   returns a response (read data, error flag, store echo) under valid/ready.
//
//   Optional feature macro: DMEM_WAIT_STATES_EN
//     defined   : every access spends WAIT cycles in a WAIT state before RESP.
//     undefined : WAIT state and counter are not built; WAIT is ignored.
//
// Parameters
//   DEPTH : number of 32-bit words implemented (legal addresses 0..DEPTH-1)
//   WAIT  : wait states per access, 0..15 (only with DMEM_WAIT_STATES_EN)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_we     in   1 = store, 0 = load
//   req_addr   in   14-bit word address
//   req_wdata  in   32-bit store data
//   req_ready  out  responder idle and able to accept
//   rsp_valid  out  response present
//   rsp_ready  in   consumer takes the response
//   rsp_rdata  out  load data (0 for stores and out-of-range accesses)
//   rsp_err    out  address was >= DEPTH
//   rsp_we     out  echo of req_we for the accepted request
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH = 4096,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [13:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_we
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [14:0] DEPTH_LIM = 15'(DEPTH);

   if (WAIT < 0 || WAIT > 15) begin : g_wait_range
      $error("dmem_responder: WAIT must be in 0..15");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RESP = 2'd1
`ifdef DMEM_WAIT_STATES_EN
      , S_WAIT = 2'd2
`endif
   } state_t;

   state_t state, state_next;

   logic          accept;
   logic          err_in;
   logic          enter_resp;
   logic          rd_we;
   logic          rd_err;
   logic [AW-1:0] rd_addr;
   logic [31:0]   rd_data;

   logic [31:0]   mem [DEPTH];

   assign accept     = req_valid && req_ready;
   assign err_in     = ({1'b0, req_addr} >= DEPTH_LIM);
   assign enter_resp = (state != S_RESP) && (state_next == S_RESP);

`ifdef DMEM_WAIT_STATES_EN
   localparam bit         USE_WAIT  = (WAIT > 0);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

   logic [3:0]    cnt;
   logic [AW-1:0] addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         addr_q <= '0;
      end else begin
         if (accept) begin
            cnt    <= WAIT_LOAD;
            addr_q <= req_addr[AW-1:0];
         end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
`ifdef DMEM_WAIT_STATES_EN
               state_next = USE_WAIT ? S_WAIT : S_RESP;
`else
               state_next = S_RESP;
`endif
            end
         end
`ifdef DMEM_WAIT_STATES_EN
         S_WAIT: begin
            if (cnt == '0) state_next = S_RESP;
         end
`endif
         S_RESP: begin
            if (rsp_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_RESP);
   end

   // RESP can be entered straight from IDLE (accept edge) or from WAIT, so the
   // read port takes the live request in IDLE and the latched one in WAIT.
   always_comb begin
      rd_we   = req_we;
      rd_err  = err_in;
      rd_addr = req_addr[AW-1:0];
`ifdef DMEM_WAIT_STATES_EN
      if (state == S_WAIT) begin
         rd_we   = rsp_we;
         rd_err  = rsp_err;
         rd_addr = addr_q;
      end
`endif
   end

   assign rd_data = (rd_we || rd_err) ? '0 : mem[rd_addr];

   // Store completes at the accept edge; out-of-range stores are dropped.
   always_ff @(posedge clk) begin
      if (accept && !rst && req_we && !err_in)
         mem[req_addr[AW-1:0]] <= req_wdata;
   end

   // Response registers: err/we captured at accept, data on entry to RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rsp_we    <= 1'b0;
      end else begin
         if (accept) begin
            rsp_err <= err_in;
            rsp_we  <= req_we;
         end
         if (enter_resp) rsp_rdata <= rd_data;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. Two instances share all inputs:
//   one with DEPTH=4096 (range-error boundary) and one with DEPTH=16384 (full
//   14-bit address space). Expected responses come from per-instance
//   associative-array memory models and the latency/spacing rules.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH_S = 4096;
   localparam int DEPTH_B = 16384;
   localparam int WAIT_P  = 2;
`ifdef DMEM_WAIT_STATES_EN
   localparam int W = WAIT_P;
`else
   localparam int W = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [13:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;

   logic        rdy_s, vld_s, err_s, we_s;
   logic [31:0] rd_s;
   logic        rdy_b, vld_b, err_b, we_b;
   logic [31:0] rd_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_q[$];

   logic [31:0] mdl_s [int];
   logic [31:0] mdl_b [int];

   dmem_responder #(.DEPTH(DEPTH_S), .WAIT(WAIT_P)) dut_s (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy_s),
      .rsp_valid(vld_s), .rsp_ready(rsp_ready), .rsp_rdata(rd_s),
      .rsp_err(err_s), .rsp_we(we_s)
   );

   dmem_responder #(.DEPTH(DEPTH_B), .WAIT(WAIT_P)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy_b),
      .rsp_valid(vld_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b),
      .rsp_err(err_b), .rsp_we(we_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (req_valid && rdy_s && !rst) acc_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input bit big, input logic we,
                                            input logic [13:0] addr,
                                            output bit known, output logic err);
      int depth;
      depth = big ? DEPTH_B : DEPTH_S;
      err   = (int'(addr) >= depth);
      known = 1'b1;
      if (we || err) return 32'd0;
      if (big && mdl_b.exists(int'(addr))) return mdl_b[int'(addr)];
      if (!big && mdl_s.exists(int'(addr))) return mdl_s[int'(addr)];
      known = 1'b0;
      return 32'd0;
   endfunction

   task automatic model_update(input logic we, input logic [13:0] addr, input logic [31:0] wd);
      if (we) begin
         if (int'(addr) < DEPTH_S) mdl_s[int'(addr)] = wd;
         if (int'(addr) < DEPTH_B) mdl_b[int'(addr)] = wd;
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_ready_s", 32'(rdy_s), 32'd1);
      chk("rst_rsp_valid_s", 32'(vld_s), 32'd0);
      chk("rst_rsp_rdata_s", rd_s, 32'd0);
      chk("rst_rsp_err_s", 32'(err_s), 32'd0);
      chk("rst_rsp_we_s", 32'(we_s), 32'd0);
      chk("rst_req_ready_b", 32'(rdy_b), 32'd1);
      chk("rst_rsp_valid_b", 32'(vld_b), 32'd0);
      chk("rst_rsp_rdata_b", rd_b, 32'd0);
      chk("rst_rsp_we_b", 32'(we_b), 32'd0);
   endtask

   // Presents one request from IDLE; returns 1 time unit after the accept edge.
   task automatic start_req(input logic we, input logic [13:0] addr, input logic [31:0] wd);
      @(negedge clk);
      chk("idle_req_ready_s", 32'(rdy_s), 32'd1);
      chk("idle_req_ready_b", 32'(rdy_b), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      model_update(we, addr, wd);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (vld_s !== 1'b1 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic check_rsp(input logic we, input logic [13:0] addr);
      logic [31:0] r;
      logic        e;
      bit          k;
      r = model_rd(1'b0, we, addr, k, e);
      chk("rsp_valid_s", 32'(vld_s), 32'd1);
      chk("rsp_err_s", 32'(err_s), 32'(e));
      chk("rsp_we_s", 32'(we_s), 32'(we));
      if (k) chk("rsp_rdata_s", rd_s, r);
      r = model_rd(1'b1, we, addr, k, e);
      chk("rsp_valid_b", 32'(vld_b), 32'd1);
      chk("rsp_err_b", 32'(err_b), 32'(e));
      chk("rsp_we_b", 32'(we_b), 32'(we));
      if (k) chk("rsp_rdata_b", rd_b, r);
   endtask

   task automatic transact(input logic we, input logic [13:0] addr, input logic [31:0] wd,
                           input int hold, input bit poke, input logic [13:0] poke_addr);
      int          n;
      logic [31:0] h_rd_s, h_rd_b;
      rsp_ready = 1'b0;
      start_req(we, addr, wd);
      wait_rsp(n);
      chk("latency", 32'(n), 32'(W));
      check_rsp(we, addr);
      h_rd_s = rd_s;
      h_rd_b = rd_b;
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = poke_addr;
            req_wdata = 32'hBAD0_0000 | 32'(i);
         end
         @(posedge clk);
         #1;
         chk("hold_req_ready", 32'(rdy_s), 32'd0);
         chk("hold_rdata_s", rd_s, h_rd_s);
         chk("hold_rdata_b", rd_b, h_rd_b);
         check_rsp(we, addr);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("done_rsp_valid_s", 32'(vld_s), 32'd0);
      chk("done_rsp_valid_b", 32'(vld_b), 32'd0);
      chk("done_req_ready", 32'(rdy_s), 32'd1);
   endtask

   initial begin
      int          n;
      logic [13:0] a;
      logic        we;

      // Reset state
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;

      // Store then load
      transact(1'b1, 14'h0010, 32'hDEADBEEF, 0, 1'b0, '0);
      transact(1'b0, 14'h0010, 32'h0, 0, 1'b0, '0);

      // Out-of-range boundary on the 4096-word instance
      transact(1'b1, 14'h0000, 32'h1111_2222, 0, 1'b0, '0);
      transact(1'b0, 14'h1000, 32'h0, 0, 1'b0, '0);
      transact(1'b1, 14'h1000, 32'h5555_AAAA, 0, 1'b0, '0);
      transact(1'b0, 14'h0000, 32'h0, 0, 1'b0, '0);
      transact(1'b1, 14'h0FFF, 32'h0FFF_0FFF, 0, 1'b0, '0);
      transact(1'b0, 14'h0FFF, 32'h0, 0, 1'b0, '0);

      // Backpressure: held response, ignored request while busy
      transact(1'b0, 14'h0010, 32'h0, 5, 1'b1, 14'h0010);
      transact(1'b0, 14'h0010, 32'h0, 0, 1'b0, '0);

      // Asynchronous reset with an accepted store in flight
      start_req(1'b1, 14'h0030, 32'hC0FF_EE01);
      #2 rst = 1'b1;
      #1 chk_reset_vals();
      #3 rst = 1'b0;
      // Asynchronous reset while a load response is held
      start_req(1'b0, 14'h0030, 32'h0);
      wait_rsp(n);
      chk("latency_pre_rst", 32'(n), 32'(W));
      check_rsp(1'b0, 14'h0030);
      #2 rst = 1'b1;
      #1 chk_reset_vals();
      #3 rst = 1'b0;
      transact(1'b0, 14'h0030, 32'h0, 0, 1'b0, '0);

      // Back-to-back stores with rsp_ready held high
      acc_q.delete();
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 14'h3FFF;
      req_wdata = 32'h3FFF_CAFE;
      n = 0;
      while (acc_q.size() < 1 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      model_update(1'b1, 14'h3FFF, 32'h3FFF_CAFE);
      req_addr  = 14'h0000;
      req_wdata = 32'h0000_BEEF;
      while (acc_q.size() < 2 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 1'b0;
      model_update(1'b1, 14'h0000, 32'h0000_BEEF);
      repeat (W + 3) @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("b2b_accepts", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() >= 2) chk("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'(W + 2));
      transact(1'b0, 14'h3FFF, 32'h0, 0, 1'b0, '0);
      transact(1'b0, 14'h0000, 32'h0, 0, 1'b0, '0);

      // Randomized traffic against the model
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 7))
            0:       a = 14'h0000;
            1:       a = 14'h0FFF;
            2:       a = 14'h1000;
            3:       a = 14'h3FFF;
            4:       a = 14'(14'h2000 + $urandom_range(0, 7));
            default: a = 14'($urandom_range(0, 31));
         endcase
         we = 1'($urandom_range(0, 1));
         transact(we, a, $urandom, int'($urandom_range(0, 2)), 1'b0, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
